// File: rtl/wm8731_ctrl_tx.sv
// Two-wire control transmitter for the WM8731: one 3-byte register write per start request.
// Optional ACK checking is enabled by defining WM_ACK_CHECK_EN.
module wm8731_ctrl_tx #(
    parameter logic [6:0] DEV_ADDR = 7'b0011010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  quart,
    input  logic [4:0]  nbit,
    input  logic        start,
    input  logic [15:0] word,
    input  logic        sdat_i,
    output logic        sclk,
    output logic        sdat_oe,
    output logic        busy,
    output logic        done,
    output logic        nack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_RUN
    } state_e;

    localparam logic [4:0] SLOT_START = 5'd0;
    localparam logic [4:0] SLOT_STOP  = 5'd28;
    localparam logic [4:0] SLOT_END   = 5'd29;

    state_e      state_q, state_d;
    logic [1:0]  quart_q;
    logic [15:0] word_q, word_d;
    logic        sclk_q, sclk_d;
    logic        oe_q, oe_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;

    logic        tick;
    logic [26:0] frame;
    logic        slot_sclk;
    logic        slot_oe;

    assign tick  = (quart != quart_q);
    // ACK positions hold 1 so the bus is released while the codec answers.
    assign frame = {DEV_ADDR, 1'b0, 1'b1, word_q[15:8], 1'b1, word_q[7:0], 1'b1};

    // Bus levels for the slot/quarter currently presented by the counter.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        slot_sclk = 1'b1;
        slot_oe   = 1'b0;
        if (nbit == SLOT_START) begin
            slot_sclk = (quart == 2'd1) || (quart == 2'd2);
            slot_oe   = quart[1];
        end else if (nbit == SLOT_STOP) begin
            slot_sclk = (quart != 2'd0);
            slot_oe   = !quart[1];
        end else if (nbit < SLOT_STOP) begin
            slot_sclk = (quart == 2'd1) || (quart == 2'd2);
            slot_oe   = !frame[5'd27 - nbit];
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sclk_d  = sclk_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        nack_d  = nack_q;

        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b1;
                oe_d   = 1'b0;
                if (start) begin
                    word_d  = word;
                    nack_d  = 1'b0;
                    state_d = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                sclk_d = 1'b1;
                oe_d   = 1'b0;
                if (tick && (quart == 2'd0) && (nbit == SLOT_START)) begin
                    state_d = ST_RUN;
                    sclk_d  = slot_sclk;
                    oe_d    = slot_oe;
                end
            end

            ST_RUN: begin
                if (done_q) begin
                    // busy stays high through the done cycle, so a start there is ignored.
                    state_d = ST_IDLE;
                    sclk_d  = 1'b1;
                    oe_d    = 1'b0;
                end else if (tick) begin
                    if ((nbit == SLOT_END) && (quart == 2'd0)) begin
                        done_d = 1'b1;
                        sclk_d = 1'b1;
                        oe_d   = 1'b0;
                    end else begin
                        sclk_d = slot_sclk;
                        oe_d   = slot_oe;
                    end
`ifdef WM_ACK_CHECK_EN
                    if ((quart == 2'd2) && sdat_i &&
                        ((nbit == 5'd9) || (nbit == 5'd18) || (nbit == 5'd27))) begin
                        nack_d = 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifndef WM_ACK_CHECK_EN
        // The pad input is deliberately ignored in this build; nack is tied low.
        nack_d = 1'b0 & sdat_i;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            quart_q <= quart;
            word_q  <= '0;
            sclk_q  <= 1'b1;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            quart_q <= quart;
            word_q  <= word_d;
            sclk_q  <= sclk_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            nack_q  <= nack_d;
        end
    end

    assign sclk    = sclk_q;
    assign sdat_oe = oe_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign nack    = nack_q;

endmodule
